// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch control slice: FSM states, digit packing
// of the 24-bit BCD bus and the blank digit code used by the tube driver.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned BUS_W      = DIGIT_W * NUM_DIGITS;

  // Field offsets of {hr_h,hr_l,min_h,min_l,sec_h,sec_l}
  localparam int unsigned DIG_SEC_L = 0;
  localparam int unsigned DIG_SEC_H = 4;
  localparam int unsigned DIG_MIN_L = 8;
  localparam int unsigned DIG_MIN_H = 12;
  localparam int unsigned DIG_HR_L  = 16;
  localparam int unsigned DIG_HR_H  = 20;

  localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hF;

  function automatic logic [BUS_W-1:0] blank_bus();
    logic [BUS_W-1:0] b;
    b = '0;
    b[DIG_SEC_L +: DIGIT_W] = BLANK_DIGIT;
    b[DIG_SEC_H +: DIGIT_W] = BLANK_DIGIT;
    b[DIG_MIN_L +: DIGIT_W] = BLANK_DIGIT;
    b[DIG_MIN_H +: DIGIT_W] = BLANK_DIGIT;
    b[DIG_HR_L  +: DIGIT_W] = BLANK_DIGIT;
    b[DIG_HR_H  +: DIGIT_W] = BLANK_DIGIT;
    return b;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// Single-key conditioner: 2-FF synchronizer, stability counter and a
// one-clock press pulse on each accepted press (active-low key).
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter clears on acceptance or on any agreeing sample, so it never passes CNT_LAST.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced keys, mode FSM, counter enable/clear
// and live/lap display select. Optional pause blink: STOPWATCH_PAUSE_BLINK_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_CYCLES    = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_ss_n,
  input  logic             key_lap_n,
  input  logic             key_clr_n,
  input  logic [BUS_W-1:0] live_bcd,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [BUS_W-1:0] disp_bcd,
  output logic [1:0]       state_o
);

  if (DEBOUNCE_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_param_check
    $error("stopwatch_ctrl: DEBOUNCE_CYCLES and BLINK_CYCLES must be >= 1");
  end

  logic ss_p, lap_p, clr_p;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_ss_n), .press_o(ss_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_lap_n), .press_o(lap_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_clr_n), .press_o(clr_p)
  );

  sw_state_e        state_q, state_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_clr_q, cnt_clr_d;
  logic [BUS_W-1:0] disp_q, disp_d;
  logic [BUS_W-1:0] lap_q, lap_d;
  logic             clr_act, lap_load;
  logic             win_clr, win_ss, win_lap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      disp_q    <= '0;
      lap_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      disp_q    <= disp_d;
      lap_q     <= lap_d;
    end
  end

  // One winner per cycle (clr > ss > lap); a winner the state ignores still suppresses the others.
  assign win_clr = clr_p;
  assign win_ss  = ss_p & ~clr_p;
  assign win_lap = lap_p & ~clr_p & ~ss_p;

  always_comb begin
    state_d  = state_q;
    clr_act  = 1'b0;
    lap_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_clr)     clr_act = 1'b1;
        else if (win_ss) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (win_ss) begin
          state_d = ST_PAUSE;
        end else if (win_lap) begin
          state_d  = ST_LAP;
          lap_load = 1'b1;
        end
      end
      ST_LAP: begin
        if (win_ss)       state_d = ST_PAUSE;
        else if (win_lap) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (win_clr) begin
          state_d = ST_IDLE;
          clr_act = 1'b1;
        end else if (win_ss) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef STOPWATCH_PAUSE_BLINK_EN
  localparam int unsigned      BLK_W    = $clog2(BLINK_CYCLES + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Restart on PAUSE entry so the first half-period shows digits.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (state_d == ST_PAUSE && state_q != ST_PAUSE) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q >= BLK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end
`endif

  always_comb begin
    cnt_en_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
    cnt_clr_d = clr_act;
    lap_d     = lap_load ? live_bcd : lap_q;
    disp_d    = (state_d == ST_LAP) ? lap_d : live_bcd;
`ifdef STOPWATCH_PAUSE_BLINK_EN
    if (state_d == ST_PAUSE && phase_d) disp_d = blank_bus();
`endif
  end

  assign cnt_en   = cnt_en_q;
  assign cnt_clr  = cnt_clr_q;
  assign disp_bcd = disp_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: sample-window key model plus
// mode-rule model compared every cycle, with literal spot checks.
module tb_stopwatch_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned BLK = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_ss_n = 1'b1, key_lap_n = 1'b1, key_clr_n = 1'b1;
  logic [23:0] live_bcd = 24'h0;
  logic        cnt_en, cnt_clr;
  logic [23:0] disp_bcd;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BLK)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_ss_n(key_ss_n), .key_lap_n(key_lap_n), .key_clr_n(key_clr_n),
    .live_bcd(live_bcd),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .disp_bcd(disp_bcd), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // States: 0 idle, 1 run, 2 pause, 3 lap. Keys: 0 ss, 1 lap, 2 clr.
  int          m_state = 0;
  logic        m_en = 1'b0, m_clr = 1'b0;
  logic [23:0] m_disp = '0, m_lap = '0;
  int          m_age = 0;
  logic        m_lvl [3] = '{1'b1, 1'b1, 1'b1};
  logic        m_pend[3] = '{1'b0, 1'b0, 1'b0};
  logic        m_hist[3][DB+2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_en = 0; m_clr = 0; m_disp = '0; m_lap = '0; m_age = 0;
      for (int i = 0; i < 3; i++) begin
        m_lvl[i] = 1'b1; m_pend[i] = 1'b0;
        for (int j = 0; j < int'(DB) + 2; j++) m_hist[i][j] = 1'b1;
      end
    end else begin
      int    prev;
      int    win;
      logic  raw[3];
      prev = m_state;
      win  = m_pend[2] ? 2 : m_pend[0] ? 0 : m_pend[1] ? 1 : -1;
      m_clr = 1'b0;
      case (m_state)
        0: if (win == 2) m_clr = 1'b1; else if (win == 0) m_state = 1;
        1: if (win == 0) m_state = 2; else if (win == 1) begin m_state = 3; m_lap = live_bcd; end
        3: if (win == 0) m_state = 2; else if (win == 1) m_state = 1;
        default: if (win == 2) begin m_state = 0; m_clr = 1'b1; end else if (win == 0) m_state = 1;
      endcase
      m_en  = (m_state == 1) || (m_state == 3);
      m_age = (m_state == 2 && prev != 2) ? 0 : m_age + 1;
      m_disp = (m_state == 3) ? m_lap : live_bcd;
`ifdef STOPWATCH_PAUSE_BLINK_EN
      if (m_state == 2 && ((m_age / int'(BLK)) % 2) == 1) m_disp = 24'hFFFFFF;
`endif
      // A key level is accepted when the samples taken 2..DB+1 edges ago all disagree with it.
      raw[0] = key_ss_n; raw[1] = key_lap_n; raw[2] = key_clr_n;
      for (int i = 0; i < 3; i++) begin
        bit all_diff;
        for (int j = int'(DB) + 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
        m_hist[i][0] = raw[i];
        all_diff = 1'b1;
        for (int j = 2; j <= int'(DB) + 1; j++) if (m_hist[i][j] == m_lvl[i]) all_diff = 1'b0;
        m_pend[i] = all_diff && m_lvl[i];
        if (all_diff) m_lvl[i] = ~m_lvl[i];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("state_o", 32'(state_o), 32'(m_state));
      check("cnt_en", 32'(cnt_en), 32'(m_en));
      check("cnt_clr", 32'(cnt_clr), 32'(m_clr));
      check("disp_bcd", 32'(disp_bcd), 32'(m_disp));
      if (cnt_clr && cnt_en) check("clr_while_en", 32'(1), 32'(0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_set(input int k, input logic v);
    case (k)
      0: key_ss_n = v;
      1: key_lap_n = v;
      default: key_clr_n = v;
    endcase
  endtask

  task automatic press(input int k);
    key_set(k, 1'b0); tick(10);
    key_set(k, 1'b1); tick(10);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick(1);
    cmp_on = 1'b1;
    tick(2);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_disp", 32'(disp_bcd), 32'd0);
    check("rst_en_clr", 32'({cnt_en, cnt_clr}), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // 3-clock glitch is rejected
    key_ss_n = 1'b0; tick(3); key_ss_n = 1'b1; tick(12);
    check("glitch_state", 32'(state_o), 32'd0);

    press(2); // clear in IDLE: pulse only
    check("idle_clr_state", 32'(state_o), 32'd0);

    // exact latency: RUN at DB+2+1 clocks after the fall
    live_bcd = 24'h000100;
    key_ss_n = 1'b0; tick(6);
    check("ss_lat_before", 32'(state_o), 32'd0);
    tick(1);
    check("ss_lat_state", 32'(state_o), 32'd1);
    check("ss_lat_en", 32'(cnt_en), 32'd1);
    tick(3); key_ss_n = 1'b1; tick(10);

    press(2);
    check("run_clr_ignored", 32'(state_o), 32'd1);

    live_bcd = 24'h012345;
    press(1);
    live_bcd = 24'h012350; tick(3);
    check("lap_state", 32'(state_o), 32'd3);
    check("lap_frozen", 32'(disp_bcd), 32'h012345);

    key_lap_n = 1'b0; tick(7);
    check("unlap_state", 32'(state_o), 32'd1);
    check("unlap_live", 32'(disp_bcd), 32'h012350);
    live_bcd = 24'h012351; tick(1);
    check("live_follow", 32'(disp_bcd), 32'h012351);
    tick(2); key_lap_n = 1'b1; tick(10);

    // RUN -> PAUSE, blink timing relative to entry edge
    live_bcd = 24'h001122;
    key_ss_n = 1'b0; tick(7);
    check("pause_state", 32'(state_o), 32'd2);
    check("pause_en", 32'(cnt_en), 32'd0);
    check("pause_disp0", 32'(disp_bcd), 32'h001122);
    tick(3); key_ss_n = 1'b1; tick(5);
`ifdef STOPWATCH_PAUSE_BLINK_EN
    check("pause_disp8", 32'(disp_bcd), 32'hFFFFFF);
`else
    check("pause_disp8", 32'(disp_bcd), 32'h001122);
`endif
    tick(8);
    check("pause_disp16", 32'(disp_bcd), 32'h001122);

    // PAUSE clear: single-cycle pulse
    key_clr_n = 1'b0; tick(6);
    check("clr_pre", 32'(cnt_clr), 32'd0);
    tick(1);
    check("clr_pulse", 32'(cnt_clr), 32'd1);
    check("clr_state", 32'(state_o), 32'd0);
    check("clr_en", 32'(cnt_en), 32'd0);
    tick(1);
    check("clr_post", 32'(cnt_clr), 32'd0);
    tick(2); key_clr_n = 1'b1; tick(10);

    // simultaneous ss+lap in RUN -> PAUSE
    press(0);
    live_bcd = 24'h000305;
    key_ss_n = 1'b0; key_lap_n = 1'b0; tick(7);
    check("sim_ss_lap_state", 32'(state_o), 32'd2);
    check("sim_ss_lap_disp", 32'(disp_bcd), 32'h000305);
    tick(3); key_ss_n = 1'b1; key_lap_n = 1'b1; tick(10);

    // simultaneous clr+ss in PAUSE -> IDLE with clear
    key_ss_n = 1'b0; key_clr_n = 1'b0; tick(7);
    check("sim_clr_ss_state", 32'(state_o), 32'd0);
    check("sim_clr_ss_pulse", 32'(cnt_clr), 32'd1);
    tick(3); key_ss_n = 1'b1; key_clr_n = 1'b1; tick(10);

    // reset in LAP, key held through release
    press(0);
    press(1);
    check("pre_rst_lap", 32'(state_o), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state_o), 32'd0);
    check("async_rst_out", 32'({cnt_en, cnt_clr, disp_bcd}), 32'd0);
    key_ss_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("held_before", 32'(state_o), 32'd0);
    tick(1);
    check("held_run", 32'(state_o), 32'd1);
    tick(5); key_ss_n = 1'b1; tick(15);
    check("held_once", 32'(state_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch. It debounces three raw board keys (start/stop, lap, clear) and runs the mode FSM. It drives enable and clear to the BCD time counter. It selects whether live or lap-frozen digits feed the 6-digit tube driver, sitting between the key pins, the time counter and the display driver.

Parameters:
DEBOUNCE_CYCLES, 1000000, clocks a synchronized key level must stay stable before it is accepted (20 ms @ 50 MHz; benches override to 4)
BLINK_CYCLES, 25000000, half-period of pause blink in clocks (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
key_ss_n  in  1  raw start/stop key, low = pressed, asynchronous
key_lap_n  in  1  raw lap key, low = pressed, asynchronous
key_clr_n  in  1  raw clear key, low = pressed, asynchronous
live_bcd  in  24  live counter digits {hr_h,hr_l,min_h,min_l,sec_h,sec_l}, 4 bits each
cnt_en  out  1  time counter count enable, level
cnt_clr  out  1  time counter synchronous clear, one-cycle pulse
disp_bcd  out  24  digits to tube driver, same packing as live_bcd
state_o  out  2  current state (IDLE=0, RUN=1, PAUSE=2, LAP=3)

Behaviour:
- Key path, per key:
  - 2-FF synchronizer, then a stability counter.
  - The debounced level updates when the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive clocks; any shorter glitch restarts the count and is rejected.
  - A debounced 1->0 transition produces a one-clock press pulse. Release produces nothing.
- FSM transitions: state register, all outputs registered and updated on the edge that consumes a press pulse.
  - IDLE: ss -> RUN. clr -> stay IDLE, pulse cnt_clr. lap ignored.
  - RUN: ss -> PAUSE. lap -> LAP and latch live_bcd into lap_reg. clr ignored.
  - LAP: lap -> RUN (live view restored). ss -> PAUSE, live view. clr ignored.
  - PAUSE: ss -> RUN. clr -> IDLE, pulse cnt_clr. lap ignored.
- Simultaneous press pulses in one cycle: priority clr > ss > lap. Only the winner acts; losers are discarded, not queued.
- cnt_en = 1 in RUN and LAP, otherwise 0. Asserts on the same edge the state enters RUN.
- cnt_clr: exactly one cycle high per accepted clear; never high while cnt_en=1.
- disp_bcd: registered, 1-clock latency. Equals lap_reg in LAP, otherwise live_bcd.
- lap_reg is loaded only on the RUN->LAP transition and holds otherwise.
- Reset values: state IDLE, state_o 0, cnt_en 0, cnt_clr 0, disp_bcd 0, lap_reg 0, debounced levels 1 (released), stability counters 0.
- Reset mid-operation: everything returns to IDLE with no cnt_clr pulse; the counter relies on its own reset. A key held across reset release yields one press after DEBOUNCE_CYCLES+2 clocks.
- Width rules:
  - Stability counter width is $clog2(DEBOUNCE_CYCLES+1).
  - The counter saturates; it does not wrap.

Optional Feature:
Macro STOPWATCH_PAUSE_BLINK_EN.
- Defined:
  - A free-running blink counter toggles a phase bit every BLINK_CYCLES clocks.
  - In PAUSE with the phase bit = 1, disp_bcd is forced to all 4'hF; the driver decodes non-BCD to blank.
  - Phase resets to 0 on entry to PAUSE, so the first BLINK_CYCLES show digits.
- Undefined: no blink logic; PAUSE shows live_bcd steadily.

Decomposition:
- Package stopwatch_pkg holds:
  - the state encoding constants (IDLE/RUN/PAUSE/LAP, 2 bits);
  - the blank digit code 4'hF;
  - the digit field offsets within the 24-bit bus.
- Sub-module key_debounce (sync + stability counter + press pulse, parameter DEBOUNCE_CYCLES) is instantiated three times.

Test Plan:
- Debounce filter, DEBOUNCE_CYCLES=4: key_ss_n low for 3 clocks then high -> no press, state stays IDLE. Low for 10 clocks -> exactly one press; state_o=1 and cnt_en=1 at 4+2+1 clocks after the falling edge.
- Lap freeze: in RUN with live_bcd=24'h012345, press lap -> state_o=3 and disp_bcd holds 24'h012345 while live_bcd advances to 24'h012350. Press lap again -> disp_bcd follows live one clock later.
- Clear rules:
  - clr in RUN -> ignored, cnt_clr stays 0.
  - ss then clr -> PAUSE then IDLE with cnt_clr high exactly one clock and cnt_en=0.
- Simultaneity: in RUN, ss and lap press pulses in the same cycle -> PAUSE, lap_reg unchanged. In PAUSE, clr and ss together -> IDLE plus cnt_clr pulse.
- Reset mid-run: assert rst_n low in LAP -> all outputs 0, state_o=0 asynchronously. Holding key_ss_n low through release -> one RUN entry after debounce.
- With STOPWATCH_PAUSE_BLINK_EN, BLINK_CYCLES=8: in PAUSE, disp_bcd alternates live / 24'hFFFFFF every 8 clocks starting with live. Without it, steady live.
